qspi_rx_packer: RTL and testbench

Parametrised receive datapath for the QSPI master. Captures read data from the flash pins in single, dual, quad or octal lane mode, in SDR or DDR. Assembles the bytes MSB-first into little-endian words and buffers them in an internal FIFO for the AHB read side. It replaces the fixed 4-lane receive path and adds octal lanes, programmable byte length, partial-word flush and overflow reporting.

---
 rtl/qspi_rx_packer.sv | 198 +++++++++++++++++++
 tb/tb_qspi_rx_packer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rx_packer.sv
// QSPI receive datapath: captures 1/2/4/8-lane SDR or DDR read data, packs bytes into
// little-endian words and buffers them in a first-word-fall-through FIFO.
module qspi_rx_packer #(
  parameter int unsigned LANES_MAX  = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 9,
  localparam int unsigned LvlW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 sys_clk,
  input  logic                 a_res_n,
  input  logic                 start,
  input  logic [1:0]           lane_mode,
  input  logic                 ddr_en,
  input  logic [CNT_W-1:0]     byte_len,
  input  logic                 sclk_rise,
  input  logic                 sclk_fall,
  input  logic [LANES_MAX-1:0] qio_in,
  input  logic                 pop,
  input  logic                 clear,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic [LvlW-1:0]      rx_level,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned SlotW = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StCapture, StFlush, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               ddr_q, ddr_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [7:0]         byte_q, byte_d;
  logic [3:0]         bcnt_q, bcnt_d;
  logic [SlotW-1:0]   slot_q, slot_d;
  logic [DATA_W-1:0]  word_q, word_d;

  logic [7:0]         shifted;
  logic [3:0]         inc;
  logic [3:0]         bcnt_next;
  logic [DATA_W-1:0]  word_merge;
  logic               sample_en;
  logic               push;
  logic [DATA_W-1:0]  push_data;

  // Both strobes in one cycle still count as a single sample.
  assign sample_en = (state_q == StCapture) && (sclk_rise || (ddr_q && sclk_fall));
  assign bcnt_next = bcnt_q + inc;

  always_comb begin
    shifted = byte_q;
    inc     = 4'd1;
    case (mode_q)
      2'b00: begin shifted = {byte_q[6:0], qio_in[1]};   inc = 4'd1; end
      2'b01: begin shifted = {byte_q[5:0], qio_in[1:0]}; inc = 4'd2; end
      2'b10: begin shifted = {byte_q[3:0], qio_in[3:0]}; inc = 4'd4; end
      default: begin shifted = qio_in[7:0];              inc = 4'd8; end
    endcase
  end

  always_comb begin
    word_merge = word_q;
    for (int s = 0; s < Bytes; s++) begin
      if (slot_q == SlotW'(s)) word_merge[8*s +: 8] = shifted;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ddr_d     = ddr_q;
    rem_d     = rem_q;
    byte_d    = byte_q;
    bcnt_d    = bcnt_q;
    slot_d    = slot_q;
    word_d    = word_q;
    push      = 1'b0;
    push_data = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = lane_mode;
          ddr_d   = ddr_en;
          rem_d   = byte_len;
          byte_d  = '0;
          bcnt_d  = '0;
          slot_d  = '0;
          word_d  = '0;
          state_d = (byte_len == '0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (sample_en) begin
          if (bcnt_next == 4'd8) begin
            byte_d = '0;
            bcnt_d = '0;
            rem_d  = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              word_d  = word_merge;
              state_d = StFlush;
            end else if (slot_q == SlotW'(Bytes - 1)) begin
              push      = 1'b1;
              push_data = word_merge;
              word_d    = '0;
              slot_d    = '0;
            end else begin
              word_d = word_merge;
              slot_d = slot_q + SlotW'(1);
            end
          end else begin
            byte_d = shifted;
            bcnt_d = bcnt_next;
          end
        end
      end
      StFlush: begin
        push    = 1'b1;
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge a_res_n) begin
    if (!a_res_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      ddr_q   <= 1'b0;
      rem_q   <= '0;
      byte_q  <= '0;
      bcnt_q  <= '0;
      slot_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ddr_q   <= ddr_d;
      rem_q   <= rem_d;
      byte_q  <= byte_d;
      bcnt_q  <= bcnt_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // FIFO
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [LvlW-1:0]   cnt_q;
  logic              do_push, do_pop;

  assign rx_level = cnt_q;
  assign rx_empty = (cnt_q == '0);
  assign rx_full  = (cnt_q == LvlW'(FIFO_DEPTH));
  assign rd_data  = rx_empty ? '0 : mem_q[rptr_q];
  assign do_pop   = pop && !rx_empty;
  // A pop on a full FIFO frees the slot the concurrent push needs.
  assign do_push  = push && (!rx_full || do_pop);

  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge sys_clk or negedge a_res_n) begin
    if (!a_res_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + LvlW'(1);
        2'b01:   cnt_q <= cnt_q - LvlW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qspi_rx_packer.sv
// Self-checking bench for qspi_rx_packer: table-driven transfers with a word scoreboard,
// plus hand sequences for zero length, overflow, pop-while-full and reset mid-capture.
module tb_qspi_rx_packer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 9;

  logic          sys_clk;
  logic          a_res_n;
  logic          start;
  logic [1:0]    lane_mode;
  logic          ddr_en;
  logic [CW-1:0] byte_len;
  logic          sclk_rise;
  logic          sclk_fall;
  logic [7:0]    qio_in;
  logic          pop;
  logic          clear;
  logic [DW-1:0] rd_data;
  logic          rx_empty;
  logic          rx_full;
  logic [2:0]    rx_level;
  logic          busy;
  logic          done;
  logic          overflow;

  qspi_rx_packer #(
    .LANES_MAX (8),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .sys_clk  (sys_clk),
    .a_res_n  (a_res_n),
    .start    (start),
    .lane_mode(lane_mode),
    .ddr_en   (ddr_en),
    .byte_len (byte_len),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .qio_in   (qio_in),
    .pop      (pop),
    .clear    (clear),
    .rd_data  (rd_data),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .rx_level (rx_level),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]  mode;
    logic        ddr;
    logic        both;
    logic        pop_push;
    logic [8:0]  len;
    logic [63:0] bytes;
    logic [1:0]  nwords;
    logic [63:0] exp;
  } vec_t;

  int          tests;
  int          fails;
  logic [31:0] sb[$];
  logic [7:0]  xbytes [32];
  vec_t        vecs [6];

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string name);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got 0x%0h expected no word", name, rd_data);
    end else begin
      check(name, 64'(rd_data), 64'(sb.pop_front()));
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 8 && !rx_empty; n++) begin
      check_head("rd_data");
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    check("rx_empty_drain", 64'(rx_empty), 64'd1);
    check("sb_left", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Drives one sample; lanes not used by the mode carry random data.
  task automatic drive_sample(input logic [1:0] mode, input logic [7:0] chunk,
                              input logic fall, input logic both);
    logic [7:0] v;
    v = 8'($urandom);
    case (mode)
      2'd0: v[1] = chunk[0];
      2'd1: v[1:0] = chunk[1:0];
      2'd2: v[3:0] = chunk[3:0];
      default: v = chunk;
    endcase
    qio_in    = v;
    sclk_rise = both | !fall;
    sclk_fall = both | fall;
    tick();
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    qio_in    = 8'($urandom);
  endtask

  // popm: 0 never pop, 1 pop on a mid-transfer push into an empty FIFO,
  // 2 pop on a push into a full FIFO (mid-transfer and flush).
  task automatic run_xfer(input logic [1:0] mode, input logic ddr, input logic both,
                          input int len, input int popm, input logic chk_lvl,
                          input int exp_lvl);
    int         bps, spb, nsamp, bdone;
    logic [7:0] chunk;
    logic       mid;
    bps   = 1 << mode;
    spb   = 8 / bps;
    nsamp = len * spb;
    start = 1'b1; lane_mode = mode; ddr_en = ddr; byte_len = CW'(len);
    tick();
    start = 1'b0; lane_mode = ~mode; ddr_en = ~ddr; byte_len = CW'($urandom);
    check("busy_rise", 64'(busy), 64'd1);
    for (int i = 0; i < nsamp; i++) begin
      chunk = 8'(xbytes[i / spb] >> (8 - bps * ((i % spb) + 1))) & 8'((1 << bps) - 1);
      bdone = (i + 1) / spb;
      mid   = ((i + 1) % spb == 0) && (bdone % 4 == 0) && (bdone < len);
      if (popm == 1 && mid && rx_empty) pop = 1'b1;
      if (popm == 2 && mid && rx_full) begin
        check_head("head_full_pop");
        pop = 1'b1;
      end
      drive_sample(mode, chunk, ddr && (i % 2 == 1), both);
      pop = 1'b0;
      if (chk_lvl)
        check("level_mid", 64'(rx_level), 64'((bdone == len) ? (len - 1) / 4 : bdone / 4));
      if (i != nsamp - 1) begin
        // Gap cycle: a stray fall strobe in SDR and a start while busy must be ignored.
        sclk_fall = !ddr;
        start     = (i == 0);
        byte_len  = '0;
        tick();
        sclk_fall = 1'b0;
        start     = 1'b0;
      end
    end
    check("done_flush", 64'(done), 64'd0);
    if (popm == 2 && rx_full) begin
      check_head("head_flush_pop");
      pop = 1'b1;
    end
    tick();
    pop = 1'b0;
    check("done_pulse", 64'(done), 64'd1);
    check("busy_done", 64'(busy), 64'd1);
    if (exp_lvl >= 0) check("level_done", 64'(rx_level), 64'(exp_lvl));
    tick();
    check("done_end", 64'(done), 64'd0);
    check("busy_fall", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input int v);
    for (int k = 0; k < 8; k++) xbytes[k] = vecs[v].bytes[8*k +: 8];
    for (int w = 0; w < int'(vecs[v].nwords); w++) sb.push_back(vecs[v].exp[32*w +: 32]);
    run_xfer(vecs[v].mode, vecs[v].ddr, vecs[v].both, int'(vecs[v].len),
             vecs[v].pop_push ? 1 : 0, 1'b1, int'(vecs[v].nwords));
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    //         mode  ddr   both  pop   len   bytes                   nw    expected words
    vecs[0] = '{2'd2, 1'b0, 1'b0, 1'b0, 9'd4, 64'h0000_0000_7856_3412, 2'd1, 64'h0000_0000_7856_3412};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b0, 9'd1, 64'h0000_0000_0000_00A5, 2'd1, 64'h0000_0000_0000_00A5};
    vecs[2] = '{2'd1, 1'b1, 1'b0, 1'b0, 9'd2, 64'h0000_0000_0000_3FC6, 2'd1, 64'h0000_0000_0000_3FC6};
    vecs[3] = '{2'd3, 1'b0, 1'b0, 1'b1, 9'd6, 64'h0000_6655_4433_2211, 2'd2, 64'h0000_6655_4433_2211};
    vecs[4] = '{2'd2, 1'b1, 1'b1, 1'b0, 9'd3, 64'h0000_0000_00BE_ADDE, 2'd1, 64'h0000_0000_00BE_ADDE};
    vecs[5] = '{2'd1, 1'b0, 1'b0, 1'b1, 9'd5, 64'h0000_0089_6745_2301, 2'd2, 64'h0000_0089_6745_2301};

    a_res_n = 1'b0; start = 1'b0; lane_mode = '0; ddr_en = 1'b0; byte_len = '0;
    sclk_rise = 1'b0; sclk_fall = 1'b0; qio_in = '0; pop = 1'b0; clear = 1'b0;
    tick();
    tick();
    check("rst_empty", 64'(rx_empty), 64'd1);
    check("rst_full", 64'(rx_full), 64'd0);
    check("rst_level", 64'(rx_level), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    a_res_n = 1'b1;
    tick();

    // Zero-length transfer: straight to DONE, nothing pushed.
    start = 1'b1; lane_mode = 2'd2; byte_len = '0;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd1);
    tick();
    check("zero_done_end", 64'(done), 64'd0);
    check("zero_empty", 64'(rx_empty), 64'd1);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Overflow: five words into a four-deep FIFO with no pops; the fifth is dropped.
    for (int k = 0; k < 20; k++) xbytes[k] = 8'(k + 1);
    for (int w = 0; w < 4; w++)
      sb.push_back({xbytes[4*w+3], xbytes[4*w+2], xbytes[4*w+1], xbytes[4*w]});
    run_xfer(2'd2, 1'b0, 1'b0, 20, 0, 1'b0, 4);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_full", 64'(rx_full), 64'd1);
    check_head("ovf_head");
    sb.delete();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_empty", 64'(rx_empty), 64'd1);
    check("clear_ovf", 64'(overflow), 64'd0);
    check("clear_level", 64'(rx_level), 64'd0);

    // Pop while full: simultaneous push and pop keeps the level and loses nothing.
    for (int k = 0; k < 24; k++) xbytes[k] = 8'(k * 7 + 3);
    for (int w = 0; w < 6; w++)
      sb.push_back({xbytes[4*w+3], xbytes[4*w+2], xbytes[4*w+1], xbytes[4*w]});
    run_xfer(2'd2, 1'b0, 1'b0, 24, 2, 1'b0, 4);
    check("pf_no_ovf", 64'(overflow), 64'd0);
    drain();

    // Reset mid-capture after five bytes (one word already buffered).
    for (int k = 0; k < 8; k++) xbytes[k] = 8'(8'hC0 + k);
    start = 1'b1; lane_mode = 2'd2; ddr_en = 1'b0; byte_len = CW'(8);
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_sample(2'd2, 8'(xbytes[i / 2] >> (4 * (1 - i % 2))) & 8'h0F, 1'b0, 1'b0);
      tick();
    end
    check("pre_rst_level", 64'(rx_level), 64'd1);
    a_res_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_empty", 64'(rx_empty), 64'd1);
    check("mid_rst_rd_data", 64'(rd_data), 64'd0);
    tick();
    a_res_n = 1'b1;
    tick();
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
